// File: rtl/gen_pixel_sink_if.sv
// Generator handshake plus framebuffer write port of the pixel sink.
// master = the sink itself, slave = generator / framebuffer side.
interface gen_pixel_sink_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 12
);
    logic                    gen_start;
    logic signed [WIDTH-1:0] gen_arg0;
    logic signed [WIDTH-1:0] gen_arg1;
    logic signed [WIDTH-1:0] gen_arg2;
    logic                    gen_ready;
    logic                    gen_valid;
    logic                    gen_done;
    logic signed [WIDTH-1:0] gen_out0;
    logic signed [WIDTH-1:0] gen_out1;
    logic                    wr_valid;
    logic                    wr_ready;
    logic [ADDR_W-1:0]       wr_addr;

    modport master (
        output gen_start, gen_arg0, gen_arg1, gen_arg2, gen_ready,
        output wr_valid, wr_addr,
        input  gen_valid, gen_done, gen_out0, gen_out1,
        input  wr_ready
    );

    modport slave (
        input  gen_start, gen_arg0, gen_arg1, gen_arg2, gen_ready,
        input  wr_valid, wr_addr,
        output gen_valid, gen_done, gen_out0, gen_out1,
        output wr_ready
    );
endinterface

// File: rtl/gen_pixel_sink.sv
// Launches a coordinate generator, clips its points to the screen and queues
// linear framebuffer addresses in a show-ahead FIFO for the write arbiter.
module gen_pixel_sink #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int SCREEN_W = 64,
    parameter int SCREEN_H = 64,
    parameter int ADDR_W   = 12
) (
    input  logic                    _clock,
    input  logic                    _reset,
    input  logic                    cmd_start,
    input  logic signed [WIDTH-1:0] cmd_arg0,
    input  logic signed [WIDTH-1:0] cmd_arg1,
    input  logic signed [WIDTH-1:0] cmd_arg2,
    gen_pixel_sink_if.master        bus,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             pixel_count,
    output logic [15:0]             clip_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic signed [WIDTH-1:0] SCR_W = WIDTH'(SCREEN_W);
    localparam logic signed [WIDTH-1:0] SCR_H = WIDTH'(SCREEN_H);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            sat_inc = v;
        end else begin
            sat_inc = v + 16'd1;
        end
    endfunction

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic signed [WIDTH-1:0] arg0_r;
    logic signed [WIDTH-1:0] arg1_r;
    logic signed [WIDTH-1:0] arg2_r;
    logic [ADDR_W-1:0]       mem_r [DEPTH];
    logic [AW-1:0]           wr_ptr_r;
    logic [AW-1:0]           rd_ptr_r;
    logic [AW:0]             count_r;
    logic [AW:0]             count_nxt_s;
    logic                    full_s;
    logic                    empty_s;
    logic                    gen_ready_s;
    logic                    in_bounds_s;
    logic [ADDR_W-1:0]       addr_s;
    logic                    accept_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    launch_s;

    assign full_s    = (count_r == (AW+1)'(DEPTH));
    assign empty_s   = (count_r == {(AW+1){1'b0}});
    assign launch_s  = (state_r == ST_IDLE) && cmd_start;
    assign accept_s  = bus.gen_valid && gen_ready_s;
    assign push_s    = accept_s && in_bounds_s;
    assign pop_s     = !empty_s && bus.wr_ready;

    // Signed bounds test; modular arithmetic in ADDR_W bits equals truncating the full product.
    assign in_bounds_s = !bus.gen_out0[WIDTH-1] && (bus.gen_out0 < SCR_W) &&
                         !bus.gen_out1[WIDTH-1] && (bus.gen_out1 < SCR_H);
    assign addr_s = bus.gen_out1[ADDR_W-1:0] * ADDR_W'(SCREEN_W) + bus.gen_out0[ADDR_W-1:0];

    // FSM state register
    always_ff @(posedge _clock) begin
        if (_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:  state_nxt_s = cmd_start ? ST_START : ST_IDLE;
            ST_START: state_nxt_s = ST_RUN;
            ST_RUN:   state_nxt_s = (bus.gen_done && gen_ready_s) ? ST_DRAIN : ST_RUN;
            ST_DRAIN: state_nxt_s = (count_nxt_s == {(AW+1){1'b0}}) ? ST_DONE : ST_DRAIN;
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output decode; ready uses the registered count so a pop never bypasses into it
    always_comb begin
        bus.gen_start = 1'b0;
        gen_ready_s   = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        case (state_r)
            ST_IDLE:  busy          = 1'b0;
            ST_START: bus.gen_start = 1'b1;
            ST_RUN:   gen_ready_s   = !full_s;
            ST_DRAIN: gen_ready_s   = 1'b0;
            ST_DONE:  done          = 1'b1;
            default:  busy          = 1'b0;
        endcase
        bus.gen_ready = gen_ready_s;
    end

    // Argument latch and per-run counters
    always_ff @(posedge _clock) begin
        if (_reset) begin
            arg0_r      <= {WIDTH{1'b0}};
            arg1_r      <= {WIDTH{1'b0}};
            arg2_r      <= {WIDTH{1'b0}};
            pixel_count <= 16'd0;
            clip_count  <= 16'd0;
        end else if (launch_s) begin
            arg0_r      <= cmd_arg0;
            arg1_r      <= cmd_arg1;
            arg2_r      <= cmd_arg2;
            pixel_count <= 16'd0;
            clip_count  <= 16'd0;
        end else if (accept_s) begin
            if (in_bounds_s) begin
                pixel_count <= sat_inc(pixel_count);
            end else begin
                clip_count  <= sat_inc(clip_count);
            end
        end
    end

    assign bus.gen_arg0 = arg0_r;
    assign bus.gen_arg1 = arg1_r;
    assign bus.gen_arg2 = arg2_r;

    // FIFO occupancy after this edge
    always_comb begin
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + (AW+1)'(1'b1);
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - (AW+1)'(1'b1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // FIFO pointers and count; pointers wrap naturally at DEPTH
    always_ff @(posedge _clock) begin
        if (_reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            count_r <= count_nxt_s;
        end
    end

    // FIFO storage, left unreset; the read port is masked while empty
    always_ff @(posedge _clock) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= addr_s;
        end
    end

    // Show-ahead write port
    always_comb begin
        bus.wr_valid = !empty_s;
        if (empty_s) begin
            bus.wr_addr = {ADDR_W{1'b0}};
        end else begin
            bus.wr_addr = mem_r[rd_ptr_r];
        end
    end
endmodule

// File: tb/tb_gen_pixel_sink.sv
// Directed bench for gen_pixel_sink: table-driven clipping/address runs plus
// hand-written backpressure, cmd_start-in-RUN, empty-run and mid-run reset sequences.
module tb_gen_pixel_sink;
    logic                clk = 1'b0;
    logic                rst;
    logic                cmd_start;
    logic signed [31:0]  cmd_arg0, cmd_arg1, cmd_arg2;
    logic                busy, done;
    logic [15:0]         pixel_count, clip_count;

    gen_pixel_sink_if #(.WIDTH(32), .ADDR_W(12)) bus ();

    gen_pixel_sink #(.WIDTH(32), .DEPTH(8), .SCREEN_W(64), .SCREEN_H(64), .ADDR_W(12)) dut (
        ._clock(clk), ._reset(rst), .cmd_start(cmd_start),
        .cmd_arg0(cmd_arg0), .cmd_arg1(cmd_arg1), .cmd_arg2(cmd_arg2),
        .bus(bus), .busy(busy), .done(done),
        .pixel_count(pixel_count), .clip_count(clip_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [31:0] x;
        logic signed [31:0] y;
        logic               in_b;
        logic [11:0]        addr;
    } vec_t;

    vec_t        vecs [14];
    int          passed = 0;
    int          total  = 0;
    int          done_cnt = 0;
    logic [11:0] got_q [$];
    logic [11:0] exp_q [$];

    // Record accepted writes and done pulses just after the falling edge
    always @(negedge clk) begin
        #1;
        if (bus.wr_valid && bus.wr_ready) got_q.push_back(bus.wr_addr);
        if (done) done_cnt++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        else passed++;
    endtask

    task automatic start_run(input logic signed [31:0] a0, a1, a2);
        cmd_start = 1'b1; cmd_arg0 = a0; cmd_arg1 = a1; cmd_arg2 = a2;
        @(negedge clk);
        cmd_start = 1'b0;
        check("gen_start", bus.gen_start, 1);
        check("gen_arg0", bus.gen_arg0, a0);
        check("gen_arg1", bus.gen_arg1, a1);
        check("gen_arg2", bus.gen_arg2, a2);
        @(negedge clk);
    endtask

    task automatic send(input logic signed [31:0] x, y, input logic with_done);
        int n = 0;
        bus.gen_valid = 1'b1; bus.gen_out0 = x; bus.gen_out1 = y; bus.gen_done = with_done;
        while (!bus.gen_ready && n < 200) begin
            @(negedge clk); n++;
        end
        check("gen_ready_wait", bus.gen_ready, 1);
        @(negedge clk);
        bus.gen_valid = 1'b0; bus.gen_done = 1'b0;
    endtask

    task automatic finish_gen();
        int n = 0;
        bus.gen_done = 1'b1;
        while (!bus.gen_ready && n < 200) begin
            @(negedge clk); n++;
        end
        check("gen_done_wait", bus.gen_ready, 1);
        @(negedge clk);
        bus.gen_done = 1'b0;
    endtask

    task automatic wait_done(input int pix, input int clip);
        int n = 0;
        while (!done && n < 300) begin
            @(negedge clk); n++;
        end
        check("done_seen", done, 1);
        check("pixel_count", pixel_count, pix);
        check("clip_count", clip_count, clip);
        @(negedge clk);
        check("busy_after_done", busy, 0);
        check("done_one_cycle", done, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic compare_writes();
        check("write_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("wr_addr[%0d]", i), got_q[i], exp_q[i]);
    endtask

    task automatic run_table(input int lo, input int hi, input int pix, input int clip);
        int d0;
        got_q.delete(); exp_q.delete();
        d0 = done_cnt;
        start_run(lo, hi, 8);
        for (int i = lo; i <= hi; i++) begin
            if (vecs[i].in_b) exp_q.push_back(vecs[i].addr);
            send(vecs[i].x, vecs[i].y, i == hi);
            if (i == lo) begin
                check("latency_wr_valid", bus.wr_valid, 1);
                check("latency_wr_addr", bus.wr_addr, vecs[i].addr);
            end
        end
        wait_done(pix, clip);
        compare_writes();
        check("done_pulses", done_cnt - d0, 1);
    endtask

    task automatic check_all_zero();
        check("rst_gen_start", bus.gen_start, 0);
        check("rst_gen_arg0", bus.gen_arg0, 0);
        check("rst_gen_arg1", bus.gen_arg1, 0);
        check("rst_gen_arg2", bus.gen_arg2, 0);
        check("rst_gen_ready", bus.gen_ready, 0);
        check("rst_wr_valid", bus.wr_valid, 0);
        check("rst_wr_addr", bus.wr_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pixel_count", pixel_count, 0);
        check("rst_clip_count", clip_count, 0);
    endtask

    initial begin
        int d0;
        // Run A: the reference four-point stream; run B: edges of the screen
        vecs[0]  = '{32'sd3,   32'sd2,  1'b1, 12'd131};
        vecs[1]  = '{32'sd70,  32'sd5,  1'b0, 12'd0};
        vecs[2]  = '{-32'sd1,  32'sd0,  1'b0, 12'd0};
        vecs[3]  = '{32'sd63,  32'sd63, 1'b1, 12'd4095};
        vecs[4]  = '{32'sd0,   32'sd0,  1'b1, 12'd0};
        vecs[5]  = '{32'sd63,  32'sd0,  1'b1, 12'd63};
        vecs[6]  = '{32'sd64,  32'sd0,  1'b0, 12'd0};
        vecs[7]  = '{32'sd0,   32'sd63, 1'b1, 12'd4032};
        vecs[8]  = '{32'sd0,   32'sd64, 1'b0, 12'd0};
        vecs[9]  = '{32'sd5,   -32'sd1, 1'b0, 12'd0};
        vecs[10] = '{32'sd10,  32'sd20, 1'b1, 12'd1290};
        vecs[11] = '{32'sh80000000, 32'sd0, 1'b0, 12'd0};
        vecs[12] = '{32'sd31,  32'sd32, 1'b1, 12'd2079};
        vecs[13] = '{32'sd1,   32'sd1,  1'b1, 12'd65};

        rst = 1'b1; cmd_start = 1'b0; cmd_arg0 = 32'sd0; cmd_arg1 = 32'sd0; cmd_arg2 = 32'sd0;
        bus.gen_valid = 1'b0; bus.gen_done = 1'b0; bus.gen_out0 = 32'sd0; bus.gen_out1 = 32'sd0;
        bus.wr_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_all_zero();

        run_table(0, 3, 2, 2);
        run_table(4, 13, 6, 4);

        // Generator finishes at once: zero points, still one done
        d0 = done_cnt;
        start_run(-32'sd4, 32'sd5, -32'sd6);
        finish_gen();
        wait_done(0, 0);
        check("empty_run_done", done_cnt - d0, 1);

        // Backpressure: 10 points into an 8-deep FIFO, plus cmd_start during RUN
        got_q.delete(); exp_q.delete();
        bus.wr_ready = 1'b0;
        start_run(32'sd1, 32'sd2, 32'sd3);
        cmd_start = 1'b1; cmd_arg0 = 32'sd99; cmd_arg1 = 32'sd98; cmd_arg2 = 32'sd97;
        @(negedge clk);
        cmd_start = 1'b0;
        check("ign_gen_start", bus.gen_start, 0);
        check("ign_gen_arg0", bus.gen_arg0, 1);
        check("ign_gen_arg1", bus.gen_arg1, 2);
        check("ign_gen_arg2", bus.gen_arg2, 3);
        check("ign_busy", busy, 1);
        for (int i = 0; i < 10; i++) exp_q.push_back(12'(64 + i));
        fork
            begin
                for (int i = 0; i < 10; i++) send(i, 32'sd1, 1'b0);
            end
            begin
                repeat (20) @(negedge clk);
                check("full_gen_ready", bus.gen_ready, 0);
                check("full_pixel_count", pixel_count, 8);
                check("full_wr_valid", bus.wr_valid, 1);
                check("full_wr_addr", bus.wr_addr, 64);
                bus.wr_ready = 1'b1;
            end
        join
        finish_gen();
        wait_done(10, 0);
        compare_writes();

        // Reset while three addresses are queued
        bus.wr_ready = 1'b0;
        start_run(32'sd5, 32'sd6, 32'sd7);
        send(32'sd1, 32'sd0, 1'b0);
        send(32'sd2, 32'sd0, 1'b0);
        send(32'sd3, 32'sd0, 1'b0);
        check("pre_rst_pixel_count", pixel_count, 3);
        d0 = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero();
        bus.wr_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_no_done", done_cnt - d0, 0);
        check("rst_still_empty", bus.wr_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
